// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the MIPS core pipeline control: FSM states, execution
// modes and pipeline stage indices.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_STEP_WAIT = 2'b01,
        ST_STEP_GO   = 2'b10,
        ST_HALT      = 2'b11
    } ctrl_state_t;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;

    // Stage indices in request-origin fields are carried in this many bits.
    localparam int STG_IDX_W = 3;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Mode 11 is reserved and behaves like HALT, so only the top bit matters.
    function automatic logic is_halt_mode(input logic [1:0] m);
        return m[1];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters; it sticks
// at all ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-stage stall/flush generation from stage stall
// requests, RUN/STEP/HALT execution modes and saturating performance counters.
module pipe_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int                      N_STAGES  = 5,
    parameter int                      N_REQ     = 3,
    parameter logic [N_REQ*STG_IDX_W-1:0] REQ_STAGE = {3'd3, 3'd1, 3'd0},
    parameter int                      CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    stall_req,
    input  logic [N_STAGES-1:0] flush_req,
    input  logic [1:0]          mode,
    input  logic                enter,
    output logic [N_STAGES-1:0] stall,
    output logic [N_STAGES-1:0] flush,
    output logic [1:0]          state,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    step_cnt
);

    ctrl_state_t cur_state;
    ctrl_state_t next_state;

    logic [N_STAGES-1:0]  req_stall;
    logic [N_STAGES-1:0]  req_flush;
    logic                 any_req;
    logic [STG_IDX_W-1:0] max_stg;

    logic stall_inc;
    logic step_inc;

    // The deepest requesting stage freezes itself and everything upstream of
    // it, and the stage just downstream receives a bubble.
    always_comb begin
        any_req   = 1'b0;
        max_stg   = '0;
        req_stall = '0;
        req_flush = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (stall_req[i] && (REQ_STAGE[i*STG_IDX_W +: STG_IDX_W] >= max_stg)) begin
                any_req = 1'b1;
                max_stg = REQ_STAGE[i*STG_IDX_W +: STG_IDX_W];
            end
        end
        for (int s = 0; s < N_STAGES; s++) begin
            if (any_req && (s <= int'(max_stg))) begin
                req_stall[s] = 1'b1;
            end
            if (any_req && (s == int'(max_stg) + 1)) begin
                req_flush[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_HALT;
        end else begin
            cur_state <= next_state;
        end
    end

    // A step finishes only once the PC actually advances, so a mode change
    // seen in STEP_GO is picked up later from STEP_WAIT.
    always_comb begin
        next_state = cur_state;
        stall      = '0;
        flush      = '0;
        if (rst) begin
            flush = '1;
        end else begin
            case (cur_state)
                ST_RUN, ST_STEP_GO: begin
                    stall = req_stall;
                    flush = req_flush | (flush_req & ~req_stall);
                end
                default: begin
                    stall = '1;
                end
            endcase
        end
        case (cur_state)
            ST_HALT: begin
                if (mode == MODE_RUN) begin
                    next_state = ST_RUN;
                end else if (mode == MODE_STEP) begin
                    next_state = ST_STEP_WAIT;
                end
            end
            ST_RUN: begin
                if (is_halt_mode(mode)) begin
                    next_state = ST_HALT;
                end else if (mode == MODE_STEP) begin
                    next_state = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (enter) begin
                    next_state = ST_STEP_GO;
                end else if (is_halt_mode(mode)) begin
                    next_state = ST_HALT;
                end else if (mode == MODE_RUN) begin
                    next_state = ST_RUN;
                end
            end
            ST_STEP_GO: begin
                if (!req_stall[STG_IF]) begin
                    next_state = ST_STEP_WAIT;
                end
            end
            default: begin
                next_state = ST_HALT;
            end
        endcase
    end

    assign state     = cur_state;
    assign stall_inc = req_stall[STG_IF] && ((cur_state == ST_RUN) || (cur_state == ST_STEP_GO));
    assign step_inc  = (cur_state == ST_STEP_GO) && !req_stall[STG_IF];

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_step_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (step_inc),
        .count (step_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: reset, request-derived stall/flush, STEP
// mode sequencing, mid-step reset and counter saturation (narrow instance).
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic       rst4;
    logic [2:0] stall_req;
    logic [4:0] flush_req;
    logic [1:0] mode;
    logic       enter;

    logic [4:0]  stall;
    logic [4:0]  flush;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] step_cnt;

    logic [4:0] stall4;
    logic [4:0] flush4;
    logic [1:0] state4;
    logic [3:0] cycle_cnt4;
    logic [3:0] stall_cnt4;
    logic [3:0] step_cnt4;

    int n_checks;
    int n_fail;

    pipe_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .stall_req (stall_req),
        .flush_req (flush_req),
        .mode      (mode),
        .enter     (enter),
        .stall     (stall),
        .flush     (flush),
        .state     (state),
        .cycle_cnt (cycle_cnt),
        .stall_cnt (stall_cnt),
        .step_cnt  (step_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst4),
        .stall_req (stall_req),
        .flush_req (flush_req),
        .mode      (mode),
        .enter     (enter),
        .stall     (stall4),
        .flush     (flush4),
        .state     (state4),
        .cycle_cnt (cycle_cnt4),
        .stall_cnt (stall_cnt4),
        .step_cnt  (step_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; stall_req = '0; flush_req = 5'b00010; enter = 1'b0;
        step_clk(2);
        n_checks++; if (state !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_state: got %b expected %b", state, 2'b11); end
        n_checks++; if (stall !== 5'b00000) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected %b", stall, 5'b00000); end
        n_checks++; if (flush !== 5'b11111) begin n_fail++; $display("[TB] FAIL reset_flush: got %b expected %b", flush, 5'b11111); end
        n_checks++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_cycle_cnt: got %0d expected %0d", cycle_cnt, 0); end
        rst = 1'b0; flush_req = '0;
        step_clk(1);
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("[TB] FAIL run_after_reset: got %b expected %b", state, 2'b00); end
        step_clk(4);
        n_checks++; if (stall !== 5'b00000) begin n_fail++; $display("[TB] FAIL run_idle_stall: got %b expected %b", stall, 5'b00000); end
        n_checks++; if (flush !== 5'b00000) begin n_fail++; $display("[TB] FAIL run_idle_flush: got %b expected %b", flush, 5'b00000); end
        n_checks++; if (cycle_cnt !== 32'd5) begin n_fail++; $display("[TB] FAIL cycle_cnt_5: got %0d expected %0d", cycle_cnt, 5); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL stall_cnt_0: got %0d expected %0d", stall_cnt, 0); end
    endtask

    task automatic test_load_use();
        stall_req = 3'b010;
        #1;
        n_checks++; if (stall !== 5'b00011) begin n_fail++; $display("[TB] FAIL load_use_stall: got %b expected %b", stall, 5'b00011); end
        n_checks++; if (flush !== 5'b00100) begin n_fail++; $display("[TB] FAIL load_use_flush: got %b expected %b", flush, 5'b00100); end
        step_clk(1);
        stall_req = '0;
        #1;
        n_checks++; if (stall_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL load_use_stall_cnt: got %0d expected %0d", stall_cnt, 1); end
        n_checks++; if (stall !== 5'b00000) begin n_fail++; $display("[TB] FAIL load_use_release: got %b expected %b", stall, 5'b00000); end
    endtask

    task automatic test_mem_wait_flush();
        flush_req = 5'b00010;
        #1;
        n_checks++; if (flush !== 5'b00010) begin n_fail++; $display("[TB] FAIL flush_pass: got %b expected %b", flush, 5'b00010); end
        stall_req = 3'b110;
        #1;
        n_checks++; if (stall !== 5'b01111) begin n_fail++; $display("[TB] FAIL mem_wait_stall: got %b expected %b", stall, 5'b01111); end
        n_checks++; if (flush !== 5'b10000) begin n_fail++; $display("[TB] FAIL mem_wait_flush: got %b expected %b", flush, 5'b10000); end
        stall_req = 3'b001;
        #1;
        n_checks++; if (stall !== 5'b00001) begin n_fail++; $display("[TB] FAIL if_stall: got %b expected %b", stall, 5'b00001); end
        n_checks++; if (flush !== 5'b00010) begin n_fail++; $display("[TB] FAIL if_stall_flush: got %b expected %b", flush, 5'b00010); end
        stall_req = 3'b110;
        step_clk(1);
        stall_req = '0; flush_req = '0;
        #1;
        n_checks++; if (stall_cnt !== 32'd2) begin n_fail++; $display("[TB] FAIL mem_wait_stall_cnt: got %0d expected %0d", stall_cnt, 2); end
    endtask

    task automatic test_step();
        mode = 2'b01;
        step_clk(1);
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("[TB] FAIL step_wait_state: got %b expected %b", state, 2'b01); end
        stall_req = 3'b010; flush_req = 5'b00100;
        #1;
        n_checks++; if (stall !== 5'b11111) begin n_fail++; $display("[TB] FAIL step_wait_stall: got %b expected %b", stall, 5'b11111); end
        n_checks++; if (flush !== 5'b00000) begin n_fail++; $display("[TB] FAIL step_wait_flush: got %b expected %b", flush, 5'b00000); end
        stall_req = '0; flush_req = '0;
        for (int p = 0; p < 2; p++) begin
            enter = 1'b1;
            step_clk(1);
            enter = 1'b0;
            #1;
            n_checks++; if (state !== 2'b10) begin n_fail++; $display("[TB] FAIL step_go_state[%0d]: got %b expected %b", p, state, 2'b10); end
            n_checks++; if (stall !== 5'b00000) begin n_fail++; $display("[TB] FAIL step_go_stall[%0d]: got %b expected %b", p, stall, 5'b00000); end
            step_clk(1);
            n_checks++; if (state !== 2'b01) begin n_fail++; $display("[TB] FAIL step_back_wait[%0d]: got %b expected %b", p, state, 2'b01); end
            step_clk(8);
            n_checks++; if (step_cnt !== 32'(p + 1)) begin n_fail++; $display("[TB] FAIL step_cnt[%0d]: got %0d expected %0d", p, step_cnt, p + 1); end
        end
    endtask

    task automatic test_step_stalled();
        stall_req = 3'b100;
        enter = 1'b1;
        step_clk(1);
        enter = 1'b0;
        mode = 2'b10;
        #1;
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("[TB] FAIL stalled_go_state: got %b expected %b", state, 2'b10); end
        n_checks++; if (stall !== 5'b01111) begin n_fail++; $display("[TB] FAIL stalled_go_stall: got %b expected %b", stall, 5'b01111); end
        step_clk(2);
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("[TB] FAIL stalled_go_hold: got %b expected %b", state, 2'b10); end
        n_checks++; if (step_cnt !== 32'd2) begin n_fail++; $display("[TB] FAIL stalled_step_cnt_hold: got %0d expected %0d", step_cnt, 2); end
        stall_req = '0;
        step_clk(1);
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("[TB] FAIL stalled_done_wait: got %b expected %b", state, 2'b01); end
        n_checks++; if (step_cnt !== 32'd3) begin n_fail++; $display("[TB] FAIL stalled_step_cnt: got %0d expected %0d", step_cnt, 3); end
        n_checks++; if (stall_cnt !== 32'd4) begin n_fail++; $display("[TB] FAIL stalled_stall_cnt: got %0d expected %0d", stall_cnt, 4); end
        step_clk(1);
        n_checks++; if (state !== 2'b11) begin n_fail++; $display("[TB] FAIL deferred_halt: got %b expected %b", state, 2'b11); end
        enter = 1'b1;
        step_clk(1);
        enter = 1'b0;
        n_checks++; if (state !== 2'b11) begin n_fail++; $display("[TB] FAIL halt_ignores_enter: got %b expected %b", state, 2'b11); end
        mode = 2'b01;
        step_clk(2);
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("[TB] FAIL enter_not_queued: got %b expected %b", state, 2'b01); end
        n_checks++; if (step_cnt !== 32'd3) begin n_fail++; $display("[TB] FAIL enter_not_queued_cnt: got %0d expected %0d", step_cnt, 3); end
    endtask

    task automatic test_reset_mid_step();
        enter = 1'b1;
        step_clk(1);
        enter = 1'b0;
        stall_req = 3'b100;
        #1;
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("[TB] FAIL mid_step_go: got %b expected %b", state, 2'b10); end
        rst = 1'b1;
        step_clk(1);
        n_checks++; if (state !== 2'b11) begin n_fail++; $display("[TB] FAIL mid_step_reset_state: got %b expected %b", state, 2'b11); end
        n_checks++; if (flush !== 5'b11111) begin n_fail++; $display("[TB] FAIL mid_step_reset_flush: got %b expected %b", flush, 5'b11111); end
        rst = 1'b0; stall_req = '0; mode = 2'b10;
        #1;
        n_checks++; if (stall !== 5'b11111) begin n_fail++; $display("[TB] FAIL post_reset_stall: got %b expected %b", stall, 5'b11111); end
        n_checks++; if (step_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL post_reset_step_cnt: got %0d expected %0d", step_cnt, 0); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL post_reset_stall_cnt: got %0d expected %0d", stall_cnt, 0); end
        step_clk(1);
        n_checks++; if (cycle_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL post_reset_cycle_cnt: got %0d expected %0d", cycle_cnt, 1); end
        n_checks++; if (state !== 2'b11) begin n_fail++; $display("[TB] FAIL post_reset_halt: got %b expected %b", state, 2'b11); end
    endtask

    task automatic test_saturation();
        rst4 = 1'b1;
        step_clk(1);
        n_checks++; if (cycle_cnt4 !== 4'd0) begin n_fail++; $display("[TB] FAIL sat_reset: got %0d expected %0d", cycle_cnt4, 0); end
        rst4 = 1'b0;
        step_clk(14);
        n_checks++; if (cycle_cnt4 !== 4'd14) begin n_fail++; $display("[TB] FAIL sat_14: got %0d expected %0d", cycle_cnt4, 14); end
        step_clk(6);
        n_checks++; if (cycle_cnt4 !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_20: got %0d expected %0d", cycle_cnt4, 15); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst4     = 1'b1;
        test_reset();
        test_load_use();
        test_mem_wait_flush();
        test_step();
        test_step_stalled();
        test_reset_mid_step();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
